// File: rtl/sys_clk_gen_pkg.sv
// Shared types and helpers for the NCO clock-enable generator.
// Provides lock FSM states, index widths and increment math.
package sys_clk_gen_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Width of an index able to address n items (never below 1 bit).
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // round(out_hz * 2^acc_w / ref_hz)
  function automatic longint unsigned inc_from_freq(
    input longint unsigned ref_hz,
    input longint unsigned out_hz,
    input int              acc_w
  );
    return ((out_hz << acc_w) + (ref_hz >> 1)) / ref_hz;
  endfunction

  localparam longint unsigned DEFAULT_INC_1M2 =
    inc_from_freq(64'd50_000_000, 64'd1_200_000, 32);

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator channel: inc/phase registers, accumulator
// and the registered tick (carry) and outclk (MSB) enables.
module nco_channel #(
  parameter int               ACC_W   = 32,
  parameter logic [ACC_W-1:0] RST_INC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  input  logic             en,
  input  logic             gate,
  output logic             tick,
  output logic             outclk
);

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Program, re-arm on disable, or advance the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc    <= RST_INC;
      phase  <= '0;
      acc    <= '0;
      tick   <= 1'b0;
      outclk <= 1'b0;
    end else if (wr) begin
      inc    <= wr_inc;
      phase  <= wr_phase;
      acc    <= wr_phase;
      tick   <= 1'b0;
      outclk <= 1'b0;
    end else if (!en) begin
      acc    <= phase;
      tick   <= 1'b0;
      outclk <= 1'b0;
    end else begin
      acc    <= sum[ACC_W-1:0];
      tick   <= sum[ACC_W] & gate;
      outclk <= sum[ACC_W-1] & gate;
    end
  end

endmodule

// File: rtl/sys_clk_en_gen.sv
// Multi-channel fractional clock-enable generator with a settle/lock
// qualifier; any channel reprogram restarts the settle window.
module sys_clk_en_gen
  import sys_clk_gen_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              ACC_W       = 32,
  parameter longint unsigned DEFAULT_INC = DEFAULT_INC_1M2,
  parameter int              LOCK_CYCLES = 16
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]              cfg_inc,
  input  logic [ACC_W-1:0]              cfg_phase,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             outclk,
  output logic                          locked
);

  localparam int CH_IDX_W = ch_idx_w(NUM_CH);
  localparam int CNT_W    = ch_idx_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_CYCLES - 1);

  lock_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             wr_ok;

  assign wr_ok  = cfg_valid & cfg_ready &
                  (32'(cfg_ch) < 32'(NUM_CH));
  assign locked = (state == LOCKED);

  // Handshake ready: low only while in reset.
  always_ff @(posedge refclk) begin
    if (rst) cfg_ready <= 1'b0;
    else     cfg_ready <= 1'b1;
  end

  // Lock FSM state and settle counter registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= SETTLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state: a valid write always restarts settling.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (wr_ok) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        SETTLE: begin
          if (cnt == LAST) state_d = LOCKED;
          else             cnt_d   = cnt + CNT_W'(1);
        end
        LOCKED: state_d = LOCKED;
        default: state_d = SETTLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nco_channel #(
      .ACC_W   (ACC_W),
      .RST_INC (ACC_W'(DEFAULT_INC))
    ) u_ch (
      .clk      (refclk),
      .rst      (rst),
      .wr       (wr_ok & (cfg_ch == CH_IDX_W'(i))),
      .wr_inc   (cfg_inc),
      .wr_phase (cfg_phase),
      .en       (ch_en[i]),
      .gate     (locked),
      .tick     (tick[i]),
      .outclk   (outclk[i])
    );
  end

endmodule

// File: tb/tb_sys_clk_en_gen.sv
// Bench for sys_clk_en_gen: directed scenarios plus random traffic,
// checked against an arithmetic per-channel phase model.
module tb_sys_clk_en_gen;

  localparam int NCH = 3;
  localparam int AW  = 8;
  localparam int LC  = 16;
  localparam int MOD = 256;
  localparam longint unsigned DINC = 64'd6;

  logic            refclk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ch;
  logic [AW-1:0]   cfg_inc;
  logic [AW-1:0]   cfg_phase;
  logic [NCH-1:0]  ch_en;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  outclk;
  logic            locked;

  sys_clk_en_gen #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .DEFAULT_INC (DINC),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .ch_en     (ch_en),
    .tick      (tick),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  int m_inc [NCH];
  int m_ph  [NCH];
  int m_acc [NCH];
  int m_tick[NCH];
  int m_oc  [NCH];
  int m_since;
  int m_ready;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge, from the current (stable) inputs.
  task automatic model_edge();
    int lk;
    int wr;
    int s;
    lk = (m_since >= LC) ? 1 : 0;
    wr = (cfg_valid && m_ready != 0 && int'(cfg_ch) < NCH) ? 1 : 0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_inc[c] = int'(DINC); m_ph[c] = 0; m_acc[c] = 0;
        m_tick[c] = 0; m_oc[c] = 0;
      end
      m_since = 0;
      m_ready = 0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (wr != 0 && int'(cfg_ch) == c) begin
        m_inc[c] = int'(cfg_inc); m_ph[c] = int'(cfg_phase);
        m_acc[c] = m_ph[c]; m_tick[c] = 0; m_oc[c] = 0;
      end else if (!ch_en[c]) begin
        m_acc[c] = m_ph[c]; m_tick[c] = 0; m_oc[c] = 0;
      end else begin
        s = m_acc[c] + m_inc[c];
        m_tick[c] = (lk != 0 && s >= MOD) ? 1 : 0;
        m_acc[c] = s % MOD;
        m_oc[c] = (lk != 0 && m_acc[c] >= MOD / 2) ? 1 : 0;
      end
    end
    if (wr != 0) m_since = 0;
    else if (m_since < LC) m_since++;
    m_ready = 1;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge refclk);
    #1;
    chk("cfg_ready", int'(cfg_ready), m_ready);
    chk("locked", int'(locked), (m_since >= LC) ? 1 : 0);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("tick%0d", c), int'(tick[c]), m_tick[c]);
      chk($sformatf("outclk%0d", c), int'(outclk[c]), m_oc[c]);
    end
  endtask

  task automatic cfg_write(input int ch, input int inc, input int ph);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_inc   = AW'(inc);
    cfg_phase = AW'(ph);
    cycle();
    cfg_valid = 1'b0;
  endtask

  int nt0, nt2, noc0, noc2, lk_low;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_inc = '0; cfg_phase = '0; ch_en = '0;
    m_since = 0; m_ready = 0;
    repeat (3) cycle();
    chk("rst_locked", int'(locked), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    rst = 1'b0;
    ch_en = '1;
    lk_low = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!locked) lk_low++;
    end
    chk("lock_edges", lk_low, LC - 1);

    cfg_write(0, 64, 0);
    repeat (LC) cycle();
    nt0 = 0; noc0 = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      nt0 += int'(tick[0]);
      noc0 += int'(outclk[0]);
    end
    chk("ch0_rate64", nt0, 10);
    chk("ch0_duty64", noc0, 20);

    cfg_write(1, 64, 192);
    chk("unlock_after_wr", int'(locked), 0);
    repeat (LC + 8) cycle();

    cfg_write(3, 5, 5);
    chk("invalid_keeps_lock", int'(locked), 1);
    repeat (4) cycle();

    ch_en[2] = 1'b0;
    repeat (5) cycle();
    ch_en[2] = 1'b1;
    repeat (8) cycle();

    cfg_write(2, 0, 128);
    cfg_write(0, 128, 0);
    repeat (LC + 1) cycle();
    nt0 = 0; nt2 = 0; noc2 = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      nt0 += int'(tick[0]);
      nt2 += int'(tick[2]);
      noc2 += int'(outclk[2]);
    end
    chk("ch2_inc0_ticks", nt2, 0);
    chk("ch2_inc0_outclk", noc2, 1000);
    chk("ch0_rate128", nt0, 500);

    cfg_write(0, 64, 0);
    repeat (LC + 4) cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_outclk", int'(outclk), 0);
    rst = 1'b0;
    repeat (LC + 60) cycle();

    for (int i = 0; i < 1500; i++) begin
      cfg_valid = ($urandom_range(0, 11) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_inc   = AW'($urandom);
      cfg_phase = AW'($urandom);
      if ($urandom_range(0, 19) == 0) ch_en = NCH'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
